// File: rtl/norm_scheduler_pkg.sv
// Shared types and defaults for the ray-normalization scheduler.
package norm_scheduler_pkg;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
    } RayDirection;

    localparam int NORM_NUM_REQ      = 4;
    localparam int NORM_MAX_INFLIGHT = 32;

endpackage

// File: rtl/norm_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every ray in the pipeline.
// Push and pop in the same cycle are accepted even when full.
module norm_tag_fifo
    import norm_scheduler_pkg::*;
#(
    parameter int DEPTH = NORM_MAX_INFLIGHT,
    parameter int DW    = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            din_i,
    output logic [DW-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot being written, so a full FIFO may still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/norm_scheduler.sv
// Round-robin scheduler sharing one ray normalization pipeline among NUM_REQ
// ray-generator lanes. Results come back in issue order and are routed to the
// requester whose ID heads the tag FIFO.
module norm_scheduler
    import norm_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = NORM_NUM_REQ,
    parameter int MAX_INFLIGHT = NORM_MAX_INFLIGHT,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            enable_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  RayDirection [NUM_REQ-1:0]       req_ray_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            norm_start_o,
    output RayDirection                     norm_ray_o,
    input  logic                            norm_valid_i,
    input  RayDirection                     norm_result_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output RayDirection                     rsp_ray_o,
    output logic [ID_W-1:0]                 rsp_id_o,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
    output logic                            err_unexpected_o
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [ID_W-1:0]    rr_q, rr_d;
    logic               norm_start_q, norm_start_d;
    RayDirection        norm_ray_q, norm_ray_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    RayDirection        rsp_ray_q, rsp_ray_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               err_q, err_d;

    logic               can_issue;
    logic               grant_hit;
    logic [ID_W-1:0]    grant_id;
    logic               pop;
    logic               fifo_full, fifo_empty;
    logic [ID_W-1:0]    head_id;
    logic [CNT_W-1:0]   fifo_count;

    // A same-cycle pop does not open a slot for this cycle's grant.
    assign can_issue = enable_i && !fifo_full && !reset_i;
    assign pop       = norm_valid_i && !fifo_empty;

    // Round-robin search for the first valid requester starting at rr_q.
    always_comb begin : arb
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_id  = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grant_hit && req_valid_i[ID_W'(idx)]) begin
                    grant_hit = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
        end
    end

    assign req_ready_o = grant_hit ? (NUM_REQ'(1) << grant_id) : '0;

    // Issue, response routing and error next-state.
    always_comb begin
        rr_d         = rr_q;
        norm_start_d = grant_hit;
        norm_ray_d   = norm_ray_q;
        rsp_valid_d  = '0;
        rsp_ray_d    = rsp_ray_q;
        rsp_id_d     = rsp_id_q;
        err_d        = err_q;
        if (grant_hit) begin
            norm_ray_d = req_ray_i[grant_id];
            rr_d       = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        if (pop) begin
            rsp_valid_d = NUM_REQ'(1) << head_id;
            rsp_ray_d   = norm_result_i;
            rsp_id_d    = head_id;
        end
        // Results with no owner (e.g. stale data after a reset) are dropped and flagged.
        if (norm_valid_i && fifo_empty) err_d = 1'b1;
    end

    // Scheduler state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q         <= '0;
            norm_start_q <= 1'b0;
            norm_ray_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_ray_q    <= '0;
            rsp_id_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            norm_start_q <= norm_start_d;
            norm_ray_q   <= norm_ray_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ray_q    <= rsp_ray_d;
            rsp_id_q     <= rsp_id_d;
            err_q        <= err_d;
        end
    end

    norm_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .DW    (ID_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (grant_hit),
        .pop_i   (pop),
        .din_i   (grant_id),
        .dout_o  (head_id),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign norm_start_o     = norm_start_q;
    assign norm_ray_o       = norm_ray_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_ray_o        = rsp_ray_q;
    assign rsp_id_o         = rsp_id_q;
    assign inflight_o       = fifo_count;
    assign err_unexpected_o = err_q;

endmodule

// File: tb/tb_norm_scheduler.sv
// Bench for norm_scheduler: two instances (deep and shallow tag FIFO), each fed
// by a fixed-latency pipeline model and checked by a cycle-level scoreboard.
module tb_norm_scheduler;
    import norm_scheduler_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        RayDirection    ray;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic             enable      [2];
    logic [N-1:0]     req_valid   [2];
    RayDirection [N-1:0] req_ray  [2];
    logic [N-1:0]     req_ready   [2];
    logic             norm_start  [2];
    RayDirection      norm_ray    [2];
    logic             norm_valid  [2];
    RayDirection      norm_result [2];
    logic [N-1:0]     rsp_valid   [2];
    RayDirection      rsp_ray     [2];
    logic [IDW-1:0]   rsp_id      [2];
    logic             err         [2];
    logic [5:0]       inflight0;
    logic [2:0]       inflight1;

    int tests = 0;
    int fails = 0;

    // pipeline model state
    int          lat  [2] = '{5, 5};
    logic        pv   [2][64] = '{default: '0};
    RayDirection pd   [2][64];
    logic        inj_v [2];
    RayDirection inj_d [2];

    // scoreboard model state
    exp_t exp_q   [2][$];
    int   m_rr    [2] = '{0, 0};
    int   m_cnt   [2] = '{0, 0};
    logic m_err   [2] = '{1'b0, 1'b0};
    logic m_start [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    norm_scheduler #(.NUM_REQ(N), .MAX_INFLIGHT(32)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable[0]),
        .req_valid_i(req_valid[0]), .req_ray_i(req_ray[0]), .req_ready_o(req_ready[0]),
        .norm_start_o(norm_start[0]), .norm_ray_o(norm_ray[0]),
        .norm_valid_i(norm_valid[0]), .norm_result_i(norm_result[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ray_o(rsp_ray[0]), .rsp_id_o(rsp_id[0]),
        .inflight_o(inflight0), .err_unexpected_o(err[0]));

    norm_scheduler #(.NUM_REQ(N), .MAX_INFLIGHT(4)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable[1]),
        .req_valid_i(req_valid[1]), .req_ray_i(req_ray[1]), .req_ready_o(req_ready[1]),
        .norm_start_o(norm_start[1]), .norm_ray_o(norm_ray[1]),
        .norm_valid_i(norm_valid[1]), .norm_result_i(norm_result[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ray_o(rsp_ray[1]), .rsp_id_o(rsp_id[1]),
        .inflight_o(inflight1), .err_unexpected_o(err[1]));

    // Stand-in for the normalization datapath's arithmetic.
    function automatic RayDirection nf(input RayDirection r);
        RayDirection t;
        t.x = r.y ^ 16'h1234;
        t.y = r.z + 16'h0101;
        t.z = ~r.x;
        return t;
    endfunction

    function automatic RayDirection ray_c(input int i);
        RayDirection t;
        t.x = 16'(i * 3 + 1);
        t.y = 16'(i * 7 + 2);
        t.z = 16'(i * 11 + 5);
        return t;
    endfunction

    function automatic int maxi(input int d);
        return (d == 0) ? 32 : 4;
    endfunction

    function automatic int get_inflight(input int d);
        return (d == 0) ? int'(inflight0) : int'(inflight1);
    endfunction

    function automatic bit pipe_busy(input int d);
        for (int k = 0; k < 64; k++) if (pv[d][k]) return 1'b1;
        return 1'b0;
    endfunction

    // Fixed-latency pipeline: norm_valid appears lat cycles after norm_start.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 63; k++) begin
                pv[d][k] <= pv[d][k+1];
                pd[d][k] <= pd[d][k+1];
            end
            pv[d][63] <= 1'b0;
            pv[d][lat[d]-1] <= norm_start[d];
            pd[d][lat[d]-1] <= nf(norm_ray[d]);
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            norm_valid[d]  = pv[d][0] | inj_v[d];
            norm_result[d] = inj_v[d] ? inj_d[d] : pd[d][0];
        end
    end

    // Scoreboard: model grant/occupancy/error, push expected responses at grant, pop at rsp_valid.
    always @(negedge clk) begin : mon
        logic [N-1:0] eg;
        int gid, infl, idx;
        bit pop;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            infl = get_inflight(d);
            if (reset) begin
                tests++;
                if (req_ready[d] !== '0 || rsp_valid[d] !== '0 || norm_start[d] !== 1'b0 ||
                    infl != 0 || err[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL mon_reset[%0d] got ready=%b rsp=%b start=%b infl=%0d err=%b, expected all 0",
                             d, req_ready[d], rsp_valid[d], norm_start[d], infl, err[d]);
                end
                m_rr[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0; m_start[d] = 1'b0;
                exp_q[d].delete();
            end else begin
                tests++;
                if (norm_start[d] !== m_start[d]) begin
                    fails++;
                    $display("FAIL mon_start[%0d] got %b expected %b", d, norm_start[d], m_start[d]);
                end
                tests++;
                if (infl != m_cnt[d]) begin
                    fails++;
                    $display("FAIL mon_inflight[%0d] got %0d expected %0d", d, infl, m_cnt[d]);
                end
                tests++;
                if (err[d] !== m_err[d]) begin
                    fails++;
                    $display("FAIL mon_err[%0d] got %b expected %b", d, err[d], m_err[d]);
                end
                if (rsp_valid[d] !== '0) begin
                    tests++;
                    if (exp_q[d].size() == 0) begin
                        fails++;
                        $display("FAIL mon_rsp_unexpected[%0d] got rsp_valid=%b expected none", d, rsp_valid[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        if (rsp_valid[d] !== (N'(1) << e.id) || rsp_id[d] !== e.id || rsp_ray[d] !== e.ray) begin
                            fails++;
                            $display("FAIL mon_rsp[%0d] got v=%b id=%0d ray=%h expected v=%b id=%0d ray=%h",
                                     d, rsp_valid[d], rsp_id[d], rsp_ray[d], N'(1) << e.id, e.id, e.ray);
                        end
                    end
                end
                eg  = '0;
                gid = -1;
                if (enable[d] && m_cnt[d] < maxi(d)) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr[d] + k) % N;
                        if (gid < 0 && req_valid[d][idx]) gid = idx;
                    end
                end
                if (gid >= 0) eg = N'(1) << gid;
                tests++;
                if (req_ready[d] !== eg) begin
                    fails++;
                    $display("FAIL mon_grant[%0d] got %b expected %b", d, req_ready[d], eg);
                end
                m_start[d] = (gid >= 0);
                if (gid >= 0) begin
                    e.id  = IDW'(gid);
                    e.ray = nf(req_ray[d][gid]);
                    exp_q[d].push_back(e);
                    m_rr[d] = (gid + 1) % N;
                end
                pop = norm_valid[d] && (m_cnt[d] > 0);
                if (norm_valid[d] && m_cnt[d] == 0) m_err[d] = 1'b1;
                m_cnt[d] = m_cnt[d] + ((gid >= 0) ? 1 : 0) - (pop ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int d);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (get_inflight(d) == 0 && exp_q[d].size() == 0 && !pipe_busy(d)) break;
        end
    endtask

    task automatic test_reset();
        req_valid[0] = 4'hF;
        @(negedge clk);
        tests++;
        if (req_ready[0] !== '0 || norm_ray[0] !== '0 || rsp_ray[0] !== '0 || rsp_id[0] !== '0 ||
            err[0] !== 1'b0 || inflight0 !== '0 || rsp_valid[0] !== '0 || norm_start[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_values got ready=%b nray=%h rray=%h id=%0d err=%b infl=%0d, expected all 0",
                     req_ready[0], norm_ray[0], rsp_ray[0], rsp_id[0], err[0], inflight0);
        end
        step();
        req_valid[0] = '0;
        reset = 1'b0;
    endtask

    task automatic test_all_four();
        int starts = 0, rsp_at = -1, first_id = -1;
        lat[0] = 30;
        step();
        for (int i = 0; i < N; i++) req_ray[0][i] = ray_c(i);
        req_valid[0] = 4'hF;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tests++;
                if (req_ready[0] !== 4'b0001) begin
                    fails++;
                    $display("FAIL all4_first_grant got %b expected 0001", req_ready[0]);
                end
            end
            if (c >= 1 && c <= 40 && norm_start[0] === 1'b1) starts++;
            if (rsp_at < 0 && rsp_valid[0] !== '0) begin
                rsp_at   = c;
                first_id = int'(rsp_id[0]);
            end
        end
        tests++;
        if (starts != 40) begin
            fails++;
            $display("FAIL all4_start_rate got %0d starts expected 40", starts);
        end
        tests++;
        if (rsp_at != 32 || first_id != 0) begin
            fails++;
            $display("FAIL all4_first_rsp got cycle %0d id %0d expected cycle 32 id 0", rsp_at, first_id);
        end
        step();
        req_valid[0] = '0;
        wait_drain(0);
        tests++;
        if (inflight0 !== '0 || exp_q[0].size() != 0) begin
            fails++;
            $display("FAIL all4_drain got inflight=%0d pending=%0d expected 0/0", inflight0, exp_q[0].size());
        end
    endtask

    task automatic test_single();
        int n_rsp = 0;
        lat[0] = 5;
        step();
        req_valid[0]   = 4'b0100;
        req_ray[0][2]  = ray_c(100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready[0] !== 4'b0100) begin
                fails++;
                $display("FAIL single_ready cycle %0d got %b expected 0100", c, req_ready[0]);
            end
            step();
            if (c < 4) req_ray[0][2] = ray_c(101 + c);
            else       req_valid[0]  = '0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid[0] === 4'b0100) n_rsp++;
        end
        tests++;
        if (n_rsp != 5) begin
            fails++;
            $display("FAIL single_rsp_count got %0d expected 5", n_rsp);
        end
    endtask

    task automatic test_full();
        int grants = 0, peak = 0;
        lat[1] = 10;
        step();
        for (int i = 0; i < N; i++) req_ray[1][i] = ray_c(20 + i);
        req_valid[1] = 4'hF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 12 && req_ready[1] !== '0) grants++;
            if (int'(inflight1) > peak) peak = int'(inflight1);
            if (c == 11) begin
                tests++;
                if (req_ready[1] !== '0) begin
                    fails++;
                    $display("FAIL full_pop_no_free got %b expected 0000", req_ready[1]);
                end
            end
        end
        tests++;
        if (grants != 4) begin
            fails++;
            $display("FAIL full_grants got %0d expected 4", grants);
        end
        tests++;
        if (peak != 4) begin
            fails++;
            $display("FAIL full_peak got %0d expected 4", peak);
        end
        step();
        req_valid[1] = '0;
        wait_drain(1);
        tests++;
        if (inflight1 !== '0 || exp_q[1].size() != 0) begin
            fails++;
            $display("FAIL full_drain got inflight=%0d pending=%0d expected 0/0", inflight1, exp_q[1].size());
        end
    endtask

    task automatic test_enable();
        int n_rsp = 0;
        lat[0] = 6;
        step();
        for (int i = 0; i < N; i++) req_ray[0][i] = ray_c(40 + i);
        req_valid[0] = 4'b0001;
        @(negedge clk);
        tests++;
        if (req_ready[0] !== 4'b0001) begin
            fails++;
            $display("FAIL enable_pre_grant got %b expected 0001", req_ready[0]);
        end
        step();
        enable[0]    = 1'b0;
        req_valid[0] = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests++;
            if (req_ready[0] !== '0) begin
                fails++;
                $display("FAIL enable_off_ready cycle %0d got %b expected 0000", c, req_ready[0]);
            end
            if (rsp_valid[0] !== '0) n_rsp++;
            if (c < 7) step();
        end
        tests++;
        if (n_rsp != 1) begin
            fails++;
            $display("FAIL enable_off_rsp got %0d responses expected 1", n_rsp);
        end
        step();
        enable[0] = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready[0] !== 4'b0010) begin
            fails++;
            $display("FAIL enable_resume got %b expected 0010", req_ready[0]);
        end
        step();
        req_valid[0] = '0;
        wait_drain(0);
        tests++;
        if (inflight0 !== '0 || exp_q[0].size() != 0) begin
            fails++;
            $display("FAIL enable_drain got inflight=%0d pending=%0d expected 0/0", inflight0, exp_q[0].size());
        end
    endtask

    task automatic test_unexpected();
        RayDirection want;
        logic [N-1:0] got_v = '0;
        logic [IDW-1:0] got_id = '0;
        RayDirection got_ray = '0;
        step();
        inj_d[0] = ray_c(77);
        inj_v[0] = 1'b1;
        step();
        inj_v[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (err[0] !== 1'b1 || rsp_valid[0] !== '0) begin
            fails++;
            $display("FAIL unexp_flag got err=%b rsp=%b expected err=1 rsp=0000", err[0], rsp_valid[0]);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (err[0] !== 1'b1) begin
            fails++;
            $display("FAIL unexp_sticky got %b expected 1", err[0]);
        end
        lat[0] = 5;
        step();
        req_ray[0][1] = ray_c(55);
        want          = nf(ray_c(55));
        req_valid[0]  = 4'b0010;
        step();
        req_valid[0]  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid[0] !== '0) begin
                got_v   = rsp_valid[0];
                got_id  = rsp_id[0];
                got_ray = rsp_ray[0];
                break;
            end
        end
        tests++;
        if (got_v !== 4'b0010 || got_id !== 2'd1 || got_ray !== want) begin
            fails++;
            $display("FAIL unexp_after_rsp got v=%b id=%0d ray=%h expected v=0010 id=1 ray=%h",
                     got_v, got_id, got_ray, want);
        end
        wait_drain(0);
    endtask

    task automatic test_reset_inflight();
        int n_rsp = 0;
        lat[0] = 20;
        step();
        for (int i = 0; i < N; i++) req_ray[0][i] = ray_c(60 + i);
        req_valid[0] = 4'hF;
        repeat (6) begin
            @(negedge clk);
            step();
        end
        req_valid[0] = '0;
        @(negedge clk);
        tests++;
        if (inflight0 !== 6'd6) begin
            fails++;
            $display("FAIL rst_pre_inflight got %0d expected 6", inflight0);
        end
        step();
        reset = 1'b1;
        #1;
        tests++;
        if (inflight0 !== '0 || norm_start[0] !== 1'b0 || norm_ray[0] !== '0 || rsp_valid[0] !== '0 ||
            rsp_ray[0] !== '0 || rsp_id[0] !== '0 || err[0] !== 1'b0 || req_ready[0] !== '0) begin
            fails++;
            $display("FAIL rst_immediate got infl=%0d start=%b nray=%h rsp=%b err=%b, expected all 0",
                     inflight0, norm_start[0], norm_ray[0], rsp_valid[0], err[0]);
        end
        @(negedge clk);
        step();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rsp_valid[0] !== '0) n_rsp++;
            if (!pipe_busy(0) && c > 2) break;
        end
        @(negedge clk);
        tests++;
        if (err[0] !== 1'b1 || n_rsp != 0 || inflight0 !== '0) begin
            fails++;
            $display("FAIL rst_stale got err=%b forwarded=%0d infl=%0d expected err=1 forwarded=0 infl=0",
                     err[0], n_rsp, inflight0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            enable[d]    = 1'b1;
            req_valid[d] = '0;
            inj_v[d]     = 1'b0;
            inj_d[d]     = '0;
            for (int i = 0; i < N; i++) req_ray[d][i] = '0;
        end
        test_reset();
        test_all_four();
        test_single();
        test_full();
        test_enable();
        test_unexpected();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
